gost34_12_2015_block_framer: RTL and testbench



---
 rtl/gost34_12_2015_pkg.sv | 15 +
 rtl/gost34_12_2015_word_serializer.sv | 57 +++++
 rtl/gost34_12_2015_block_framer.sv | 120 ++++++++++++
 tb/tb_gost34_12_2015_block_framer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gost34_12_2015_pkg.sv
// Shared types for the GOST 34.12-2015 stream framer: block/word geometry and framer FSM states.
package gost34_12_2015_pkg;
    localparam int BLOCK_W = 128;
    localparam int WORD_W  = 32;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [2:0] {
        COLLECT,
        LOAD,
        ARM,
        WAIT,
        EMIT
    } framer_state_t;
endpackage

// File: rtl/gost34_12_2015_word_serializer.sv
// Holds a captured cipher result and streams it out MSB word first.
// Latency: first word valid the cycle after capture; one word per accepted handshake, outputs hold while m_tready=0.
module gost34_12_2015_word_serializer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 3
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               capture,
    input  logic [BLOCK_W-1:0] cap_dat,
    input  logic [CNT_W-1:0]   cap_nwords,
    input  logic               cap_last,
    output logic [WORD_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               done
);
    logic [BLOCK_W-1:0] res;
    logic [BLOCK_W-1:0] res_sh;
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   nwords;
    logic               last_flag;
    logic               vld;
    logic               is_final;

    assign res_sh   = res << (WORD_W * int'(idx));
    assign m_tdata  = res_sh[BLOCK_W-1 -: WORD_W];
    assign is_final = (idx == nwords - 1'b1);
    assign m_tvalid = vld;
    assign m_tlast  = vld && last_flag && is_final;
    assign done     = vld && m_tready && is_final;

    always_ff @(posedge aclk) begin
        if (areset) begin
            res       <= '0;
            idx       <= '0;
            nwords    <= '0;
            last_flag <= 1'b0;
            vld       <= 1'b0;
        end else if (capture) begin
            res       <= cap_dat;
            idx       <= '0;
            nwords    <= cap_nwords;
            last_flag <= cap_last;
            vld       <= 1'b1;
        end else if (vld && m_tready) begin
            if (is_final) begin
                vld <= 1'b0;
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/gost34_12_2015_block_framer.sv
// Packs input words into cipher blocks, drives the decrypt stage, and re-serialises its result.
// Latency: load the cycle after the final word, result after busy drops; input stalls until all output words leave.
module gost34_12_2015_block_framer #(
    parameter int          WORD_W         = gost34_12_2015_pkg::WORD_W,
    parameter int          BLOCK_W        = gost34_12_2015_pkg::BLOCK_W,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [WORD_W-1:0]  s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               s_tlast,
    output logic [WORD_W-1:0]  m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic               core_load,
    output logic [BLOCK_W-1:0] core_in,
    input  logic [BLOCK_W-1:0] core_out,
    input  logic               core_busy,
    output logic               err_timeout
);
    import gost34_12_2015_pkg::*;

    localparam int          WORDS    = BLOCK_W / WORD_W;
    localparam int          CNT_W    = $clog2(WORDS + 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    framer_state_t      state;
    framer_state_t      state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nwords;
    logic               last_flag;
    logic [BLOCK_W-1:0] blk;
    logic [31:0]        tcnt;
    logic               err_q;
    logic               s_fire;
    logic               blk_done;
    logic               tmo_hit;
    logic               capture;
    logic               ser_done;

    assign s_tready    = !areset && (state == COLLECT);
    assign s_fire      = s_tvalid && s_tready;
    assign blk_done    = s_fire && (s_tlast || cnt == CNT_W'(WORDS - 1));
    assign capture     = (state == WAIT) && !core_busy;
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (state == WAIT) && core_busy && (tcnt == TMO_LAST);
    assign core_load   = (state == LOAD);
    // The stage samples core_in while in reset to pick up its initial gamma.
    assign core_in     = areset ? iv : blk;
    assign err_timeout = err_q;

    always_ff @(posedge aclk) begin
        if (areset) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (blk_done) state_nxt = LOAD;
            LOAD:    state_nxt = ARM;
            ARM:     state_nxt = WAIT;
            WAIT: begin
                if (capture)      state_nxt = EMIT;
                else if (tmo_hit) state_nxt = COLLECT;
            end
            EMIT:    if (ser_done) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt       <= '0;
            nwords    <= '0;
            last_flag <= 1'b0;
            blk       <= '0;
            tcnt      <= '0;
            err_q     <= 1'b0;
        end else begin
            if (s_fire) begin
                blk <= blk | (BLOCK_W'(s_tdata) << (BLOCK_W - WORD_W - WORD_W * int'(cnt)));
                cnt <= cnt + 1'b1;
                if (blk_done) begin
                    nwords    <= cnt + 1'b1;
                    last_flag <= s_tlast;
                end
            end
            if (state == ARM)                   tcnt <= '0;
            else if (state == WAIT && core_busy) tcnt <= tcnt + 32'd1;
            // Block register is cleared between blocks so a short block pads with zeros.
            if (tmo_hit || ser_done) begin
                cnt <= '0;
                blk <= '0;
            end
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    gost34_12_2015_word_serializer #(
        .WORD_W (WORD_W),
        .BLOCK_W(BLOCK_W),
        .CNT_W  (CNT_W)
    ) u_ser (
        .aclk      (aclk),
        .areset    (areset),
        .capture   (capture),
        .cap_dat   (core_out),
        .cap_nwords(nwords),
        .cap_last  (last_flag),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .done      (ser_done)
    );
endmodule

// File: tb/tb_gost34_12_2015_block_framer.sv
// Directed bench for the block framer with a behavioural decrypt-stage model (busy window, result = ~block).
module tb_gost34_12_2015_block_framer;
    import gost34_12_2015_pkg::*;

    logic         aclk = 1'b0;
    logic         areset;
    block_t       iv;
    logic [31:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;
    logic         core_load;
    block_t       core_in;
    block_t       core_out = '0;
    logic         core_busy = 1'b0;
    logic         err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    gost34_12_2015_block_framer #(
        .WORD_W(32), .BLOCK_W(128), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset), .iv(iv),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .core_load(core_load), .core_in(core_in), .core_out(core_out),
        .core_busy(core_busy), .err_timeout(err_timeout)
    );

    always #5 aclk = ~aclk;

    // Decrypt-stage model and load monitor, evaluated on the falling edge.
    int     cyc = 0;
    int     loads = 0;
    int     dbl = 0;
    int     bleft = 0;
    int     busy_len = 10;
    bit     busy_hang = 0;
    bit     use_fixed = 0;
    bit     prev_load = 0;
    block_t load_q[$];
    int     load_cyc[$];

    always @(negedge aclk) begin
        cyc++;
        if (core_load) begin
            loads++;
            if (prev_load) dbl++;
            load_q.push_back(core_in);
            load_cyc.push_back(cyc);
            core_busy = 1'b1;
            bleft     = busy_len;
            core_out  = use_fixed ? {4{32'hA5A5A5A5}} : ~core_in;
        end else if (core_busy && !busy_hang) begin
            bleft--;
            if (bleft <= 0) core_busy = 1'b0;
        end
        prev_load = core_load;
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input logic [255:0] words, input int n, input logic [7:0] lastmask);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_tvalid = 1'b1;
            s_tdata  = words[255 - 32*i -: 32];
            s_tlast  = lastmask[i];
            while (!s_tready && t < 300) begin
                tick(1);
                t++;
            end
            if (t >= 300) fail_now("send_wait");
            tick(1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic recv(input int n, input bit bp, output logic [255:0] got, output logic [7:0] lasts);
        int k = 0;
        int t = 0;
        int ph = 0;
        bit stalled = 0;
        logic [31:0] hd = '0;
        logic        hl = 1'b0;
        got   = '0;
        lasts = '0;
        while (k < n && t < 600) begin
            m_tready = bp ? (ph % 3 == 0) : 1'b1;
            ph++;
            if (stalled) chk("stall_hold", 128'({m_tvalid, m_tlast, m_tdata}), 128'({1'b1, hl, hd}));
            stalled = 0;
            if (m_tvalid) begin
                chk("no_input_in_emit", 128'(s_tready), 128'(0));
                if (m_tready) begin
                    got[255 - 32*k -: 32] = m_tdata;
                    lasts[k] = m_tlast;
                    k++;
                end else begin
                    stalled = 1;
                    hd = m_tdata;
                    hl = m_tlast;
                end
            end
            tick(1);
            t++;
        end
        m_tready = 1'b0;
        if (k < n) fail_now("recv_wait");
    endtask

    typedef struct packed {
        logic [2:0]   n;
        logic [127:0] w;
        logic         last;
        logic         fixed;
        logic         bp;
        logic [127:0] exp_in;
        logic [127:0] exp_out;
        logic [3:0]   exp_last;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        logic [255:0] gw;
        logic [7:0]   gl;
        int           l0;
        logic [7:0]   lm;
        use_fixed = v.fixed;
        l0 = loads;
        lm = v.last ? (8'd1 << (int'(v.n) - 1)) : 8'd0;
        fork
            send({v.w, 128'h0}, int'(v.n), lm);
            recv(int'(v.n), v.bp, gw, gl);
        join
        tick(3);
        chk("idle_no_extra_word", 128'(m_tvalid), 128'(0));
        chk("load_count", 128'(loads - l0), 128'(1));
        chk("core_in_at_load", load_q[load_q.size()-1], v.exp_in);
        chk("out_words", gw[255:128], v.exp_out);
        chk("out_tlast", 128'(gl[3:0]), 128'(v.exp_last));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] gw;
        logic [7:0]   gl;
        int           t;
        int           l0;
        bit           saw_v;

        vecs[0] = '{n: 3'd4, w: 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978, last: 1'b1, fixed: 1'b1, bp: 1'b0,
                    exp_in: 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978,
                    exp_out: 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, exp_last: 4'b1000};
        vecs[1] = '{n: 3'd2, w: 128'hDEADBEEF_CAFEF00D_00000000_00000000, last: 1'b1, fixed: 1'b0, bp: 1'b0,
                    exp_in: 128'hDEADBEEF_CAFEF00D_00000000_00000000,
                    exp_out: 128'h21524110_35010FF2_00000000_00000000, exp_last: 4'b0010};
        vecs[2] = '{n: 3'd4, w: 128'h11112222_33334444_55556666_77778888, last: 1'b0, fixed: 1'b0, bp: 1'b1,
                    exp_in: 128'h11112222_33334444_55556666_77778888,
                    exp_out: 128'hEEEEDDDD_CCCCBBBB_AAAA9999_88887777, exp_last: 4'b0000};
        vecs[3] = '{n: 3'd3, w: 128'h00000001_80000000_FFFFFFFF_00000000, last: 1'b1, fixed: 1'b0, bp: 1'b1,
                    exp_in: 128'h00000001_80000000_FFFFFFFF_00000000,
                    exp_out: 128'hFFFFFFFE_7FFFFFFF_00000000_00000000, exp_last: 4'b0100};

        areset   = 1'b1;
        iv       = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_m_tlast", 128'(m_tlast), 128'(0));
        chk("rst_m_tdata", 128'(m_tdata), 128'(0));
        chk("rst_core_load", 128'(core_load), 128'(0));
        chk("rst_err", 128'(err_timeout), 128'(0));
        chk("rst_core_in_iv", core_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        areset = 1'b0;
        #1;
        chk("post_rst_s_tready", 128'(s_tready), 128'(1));
        chk("post_rst_core_in", core_in, 128'(0));

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);
        chk("err_clear_after_good", 128'(err_timeout), 128'(0));

        // Timeout: stage never drops busy
        busy_hang = 1;
        use_fixed = 0;
        send(256'h10101010_20202020_30303030_40404040 << 128, 4, 8'b0000_1000);
        chk("tmo_load_now", 128'(core_load), 128'(1));
        t = 0;
        saw_v = 0;
        while (!err_timeout && t < 100) begin
            tick(1);
            t++;
            if (m_tvalid) saw_v = 1;
        end
        if (t >= 100) fail_now("tmo_err_wait");
        chk("tmo_cycles_from_load", 128'(t), 128'(18));
        chk("tmo_no_output", 128'(saw_v), 128'(0));
        chk("tmo_s_tready", 128'(s_tready), 128'(1));
        busy_hang = 0;
        run_vec(vecs[0]);
        chk("tmo_err_sticky", 128'(err_timeout), 128'(1));

        // Reset while the stage is busy
        use_fixed = 0;
        send(256'h0BADF00D_0BADF00D_0BADF00D_0BADF00D << 128, 4, 8'b0000_1000);
        tick(4);
        areset = 1'b1;
        #1;
        chk("rst_wait_core_in_iv", core_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        @(posedge aclk);
        #1;
        chk("rst_wait_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_wait_m_tdata", 128'(m_tdata), 128'(0));
        chk("rst_wait_err", 128'(err_timeout), 128'(0));
        chk("rst_wait_core_load", 128'(core_load), 128'(0));
        chk("rst_wait_s_tready", 128'(s_tready), 128'(0));
        areset = 1'b0;
        #1;
        chk("rst_wait_resume", 128'(s_tready), 128'(1));
        run_vec(vecs[1]);

        // Back-to-back full blocks, s_tvalid held high across the gap
        use_fixed = 0;
        l0 = loads;
        fork
            send({128'h10000001_20000002_30000003_40000004, 128'h50000005_60000006_70000007_80000008},
                 8, 8'b1000_1000);
            recv(8, 1'b0, gw, gl);
        join
        chk("b2b_load_count", 128'(loads - l0), 128'(2));
        chk("b2b_load_a", load_q[load_q.size()-2], 128'h10000001_20000002_30000003_40000004);
        chk("b2b_load_b", load_q[load_q.size()-1], 128'h50000005_60000006_70000007_80000008);
        chk("b2b_gap_ok", 128'(load_cyc[load_cyc.size()-1] - load_cyc[load_cyc.size()-2] >= 17), 128'(1));
        chk("b2b_words_a", gw[255:128], 128'hEFFFFFFE_DFFFFFFD_CFFFFFFC_BFFFFFFB);
        chk("b2b_words_b", gw[127:0], 128'hAFFFFFFA_9FFFFFF9_8FFFFFF8_7FFFFFF7);
        chk("b2b_tlast", 128'(gl), 128'(8'b1000_1000));

        chk("load_one_cycle", 128'(dbl), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
